// File: rtl/shift_delay_counter.sv
// ---------------------------------------------------------------------------
// shift_delay_counter
//
// Sits after the 4-cycle shift-enable FSM in the timer path. While shift_ena
// is high, a 4-bit delay value is shifted in serially, MSB first. When
// shift_ena drops, the block counts down for (delay+1)*CYCLES_PER_UNIT clock
// cycles with counting asserted. It then raises done and holds it until the
// user acknowledges with ack.
//
// Parameters:
//   CYCLES_PER_UNIT  clock cycles per delay unit (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   shift_ena  in   while high, data is shifted into the delay register
//   data       in   serial delay bit, MSB first
//   ack        in   user acknowledge, honoured only in DONE
//   count      out  [3:0] delay register (shifted value / remaining units)
//   counting   out  high exactly while counting down
//   done       out  high exactly while waiting for ack
// ---------------------------------------------------------------------------
module shift_delay_counter #(
   parameter int CYCLES_PER_UNIT = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       shift_ena,
   input  logic       data,
   input  logic       ack,
   output logic [3:0] count,
   output logic       counting,
   output logic       done
);

   // The unit counter needs at least one bit, even when one cycle per unit
   // makes $clog2 return zero.
   localparam int UW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
   localparam logic [UW-1:0] UNIT_RELOAD = UW'(CYCLES_PER_UNIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    delay;
   logic [3:0]    delay_next;
   logic [UW-1:0] unit;
   logic [UW-1:0] unit_next;

   // State, delay and unit registers. Reset is asynchronous so the outputs
   // drop as soon as reset goes low, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         delay <= '0;
         unit  <= '0;
      end else begin
         state <= state_next;
         delay <= delay_next;
         unit  <= unit_next;
      end
   end

   // Next-state logic. Everything holds by default. Shifting happens only in
   // IDLE and SHIFT, so shift_ena is ignored while counting or done. In DONE,
   // ack takes priority and no shift happens on that edge, even if shift_ena
   // is also high. Each delay unit lasts from a unit reload down to zero, so
   // it spans exactly CYCLES_PER_UNIT cycles. The last unit ends when both
   // counters are zero.
   always_comb begin
      state_next = state;
      delay_next = delay;
      unit_next  = unit;
      case (state)
         IDLE: begin
            if (shift_ena) begin
               delay_next = {delay[2:0], data};
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_ena) begin
               delay_next = {delay[2:0], data};
            end else begin
               state_next = COUNT;
               unit_next  = UNIT_RELOAD;
            end
         end
         COUNT: begin
            if (unit != '0) begin
               unit_next = unit - UW'(1);
            end else if (delay != 4'd0) begin
               delay_next = delay - 4'd1;
               unit_next  = UNIT_RELOAD;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign count    = delay;
   assign counting = (state == COUNT);
   assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_delay_counter.sv
// ---------------------------------------------------------------------------
// tb_shift_delay_counter
//
// Directed bench for shift_delay_counter with CYCLES_PER_UNIT = 4. Expected
// {counting, done, count} values are pushed to a scoreboard queue as each
// stimulus step is planned. They are popped and compared one cycle at a time
// as the DUT produces output.
// ---------------------------------------------------------------------------
module tb_shift_delay_counter;

   localparam int CPU = 4;

   logic       clk;
   logic       reset;
   logic       shift_ena;
   logic       data;
   logic       ack;
   logic [3:0] count;
   logic       counting;
   logic       done;

   logic [5:0] obs;
   logic [3:0] model_reg;
   logic [5:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   shift_delay_counter #(
      .CYCLES_PER_UNIT(CPU)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .shift_ena (shift_ena),
      .data      (data),
      .ack       (ack),
      .count     (count),
      .counting  (counting),
      .done      (done)
   );

   assign obs = {counting, done, count};

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout observed=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive inputs, then wait for the next rising edge and settle 1 unit past it.
   task automatic applyStimulus(input logic se, input logic d, input logic a);
      shift_ena = se;
      data      = d;
      ack       = a;
      @(posedge clk);
      #1;
   endtask

   // Compare the observed {counting, done, count} against an expected value.
   task automatic checkOutput(input string tag, input logic [5:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b required=%b", tag, obs, expv);
      end
   endtask

   task automatic pushExp(input logic [5:0] expv);
      exp_q.push_back(expv);
   endtask

   // Pop the oldest expected value and compare it with the current output.
   task automatic popCheck(input string tag);
      logic [5:0] expv;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s observed=%b required=queued-entry", tag, obs);
      end else begin
         expv = exp_q.pop_front();
         checkOutput(tag, expv);
      end
   endtask

   // Shift n bits (taken MSB first from bits[n-1:0]) and check count after each edge.
   task automatic shiftBits(input logic [7:0] bits, input int n);
      logic b;
      for (int i = n - 1; i >= 0; i--) begin
         b = bits[i];
         model_reg = {model_reg[2:0], b};
         applyStimulus(1'b1, b, 1'b0);
         checkOutput("shift", {2'b00, model_reg});
      end
   endtask

   // Called in the first counting cycle. Queues the complete countdown and
   // the done rise, then walks through it while driving the noise inputs.
   task automatic runCountdown(input logic [3:0] d, input logic noise_se,
                               input logic noise_ack);
      int n;
      n = (int'(d) + 1) * CPU;
      for (int i = 0; i < n; i++) begin
         pushExp({1'b1, 1'b0, 4'(int'(d) - i / CPU)});
      end
      pushExp({1'b0, 1'b1, 4'd0});
      for (int i = 0; i < n; i++) begin
         popCheck("countdown");
         applyStimulus(noise_se, 1'b1, noise_ack);
      end
      popCheck("done_rise");
      model_reg = 4'd0;
   endtask

   initial begin
      $display("[TB] shift_delay_counter bench starting");
      reset     = 1'b0;
      shift_ena = 1'b0;
      data      = 1'b0;
      ack       = 1'b0;
      model_reg = 4'd0;

      // Reset state, before any clock edge.
      #3;
      checkOutput("reset_state", 6'b00_0000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_release", 6'b00_0000);

      // Basic sequence: shift 1101 = 13. ack pulses during COUNT are ignored.
      shiftBits(8'b0000_1101, 4);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCountdown(4'd13, 1'b0, 1'b1);

      // done holds for 10 cycles with ack low.
      for (int i = 0; i < 10; i++) begin
         pushExp(6'b01_0000);
         applyStimulus(1'b0, 1'b0, 1'b0);
         popCheck("done_hold");
      end
      pushExp(6'b00_0000);
      applyStimulus(1'b0, 1'b0, 1'b1);
      popCheck("ack_to_idle");

      // Zero delay: 4 counting cycles, then done.
      shiftBits(8'b0000_0000, 4);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCountdown(4'd0, 1'b0, 1'b0);
      pushExp(6'b00_0000);
      applyStimulus(1'b0, 1'b0, 1'b1);
      popCheck("ack_zero_delay");

      // Overlong shift 101001 keeps the last four bits, 1001 = 9. shift_ena
      // with data=1 held high throughout COUNT is ignored.
      shiftBits(8'b0010_1001, 6);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCountdown(4'd9, 1'b1, 1'b0);
      // shift_ena in DONE is ignored.
      pushExp(6'b01_0000);
      applyStimulus(1'b1, 1'b1, 1'b0);
      popCheck("done_ignore_shift");
      // ack and shift_ena together: return to IDLE with no shift.
      pushExp(6'b00_0000);
      applyStimulus(1'b1, 1'b1, 1'b1);
      popCheck("ack_with_shift");

      // Short shift: upper bits keep the old register contents.
      // 0000 -> 0001 -> 0011 -> 0110 gives 6.
      shiftBits(8'b0000_0110, 3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         pushExp({1'b1, 1'b0, 4'(6 - i / CPU)});
      end
      for (int i = 0; i < 6; i++) begin
         popCheck("count_before_reset");
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      exp_q.delete();

      // Async reset between edges, mid-COUNT.
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset", 6'b00_0000);
      #2;
      reset = 1'b1;
      model_reg = 4'd0;
      for (int i = 0; i < 3; i++) begin
         pushExp(6'b00_0000);
         applyStimulus(1'b0, 1'b1, 1'b0);
         popCheck("idle_after_reset");
      end

      // Shifting still works after reset: shift 0010, countdown of 2 units.
      shiftBits(8'b0000_0010, 4);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCountdown(4'd2, 1'b0, 1'b0);
      pushExp(6'b00_0000);
      applyStimulus(1'b0, 1'b0, 1'b1);
      popCheck("final_ack");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
